// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher. The key is expanded once per block into a
// 15-entry round-key file, then one inverse round is applied per clock.
// S-boxes are built from a GF(2^8) inverse plus the affine transform.
module aes256_decrypt_core (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [127:0] ciphertext_i,
  input  logic [255:0] key_i,
  output logic [127:0] plaintext_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  // Returns {0e*a, 0b*a, 0d*a, 09*a} from a shared xtime chain.
  function automatic logic [31:0] imc_terms(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  t0, t1, t2, t3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      t0 = imc_terms(s[127-32*c    -: 8]);
      t1 = imc_terms(s[127-32*c-8  -: 8]);
      t2 = imc_terms(s[127-32*c-16 -: 8]);
      t3 = imc_terms(s[127-32*c-24 -: 8]);
      // term layout: [31:24]=0e [23:16]=0b [15:8]=0d [7:0]=09
      o[127-32*c    -: 8] = t0[31:24] ^ t1[23:16] ^ t2[15:8]  ^ t3[7:0];
      o[127-32*c-8  -: 8] = t0[7:0]   ^ t1[31:24] ^ t2[23:16] ^ t3[15:8];
      o[127-32*c-16 -: 8] = t0[15:8]  ^ t1[7:0]   ^ t2[31:24] ^ t3[23:16];
      o[127-32*c-24 -: 8] = t0[23:16] ^ t1[15:8]  ^ t2[7:0]   ^ t3[31:24];
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] rk_q [15];
  logic [127:0] rk_d [15];
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  // Shared InvShiftRows + 16 inverse S-boxes, used by ROUND and FINAL.
  logic [127:0] shifted, subbed;
  assign shifted = inv_shift_rows(data_q);

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    assign subbed[127-8*g -: 8] = sbox_inv(shifted[127-8*g -: 8]);
  end

  // Key expansion: in KEYEXP cnt_q = n-2, so rk[n-2] and rk[n-1] feed rk[n].
  // rk_prev doubles as rk[r] during ROUND, where cnt_q holds r.
  logic [3:0]   kn;
  logic [127:0] rk_prev, rk_last;
  logic [31:0]  sw_in, sw_out, rcon_word, w0, w1, w2, w3;

  assign kn      = cnt_q + 4'd2;
  assign rk_prev = rk_q[cnt_q];
  assign rk_last = rk_q[cnt_q + 4'd1];
  assign sw_in   = kn[0] ? rk_last[31:0] : {rk_last[23:0], rk_last[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_fwd_sbox
    assign sw_out[8*g +: 8] = sbox_fwd(sw_in[8*g +: 8]);
  end

  assign rcon_word = kn[0] ? 32'h0 : {(8'h01 << (kn[3:1] - 3'd1)), 24'h0};
  assign w0 = rk_prev[127:96] ^ sw_out ^ rcon_word;
  assign w1 = rk_prev[95:64]  ^ w0;
  assign w2 = rk_prev[63:32]  ^ w1;
  assign w3 = rk_prev[31:0]   ^ w2;

  // Next-state and datapath updates for the five-phase block sequence.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pt_d    = pt_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          data_d  = ciphertext_i;
          rk_d[0] = key_i[255:128];
          rk_d[1] = key_i[127:0];
          cnt_d   = '0;
          state_d = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        rk_d[kn] = {w0, w1, w2, w3};
        if (cnt_q == 4'd12) state_d = S_INIT;
        else                cnt_d   = cnt_q + 4'd1;
      end
      S_INIT: begin
        data_d  = data_q ^ rk_q[14];
        cnt_d   = 4'd13;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        data_d = inv_mix_columns(subbed ^ rk_prev);
        if (cnt_q == 4'd1) state_d = S_FINAL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_FINAL: begin
        pt_d    = subbed ^ rk_q[0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, data, key file and output registers; reset discards any block.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      pt_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
    end
  end

  assign plaintext_o = pt_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// Directed and round-trip bench for aes256_decrypt_core. A forward AES-256
// model stands in for the encryption core.
module tb_aes256_decrypt_core;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_i = 1'b0;
  logic [127:0] ciphertext_i = '0;
  logic [255:0] key_i = '0;
  logic [127:0] plaintext_o;
  logic         busy_o;
  logic         done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t [256];

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] SP_CT1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] SP_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_CT2 = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] SP_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] SP_CT3 = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
  localparam logic [127:0] SP_PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] SP_CT4 = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
  localparam logic [127:0] SP_PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

  aes256_decrypt_core dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .ciphertext_i (ciphertext_i),
    .key_i        (key_i),
    .plaintext_o  (plaintext_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- forward reference model ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = tb_xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, v, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      v = inv;
      for (int k = 0; k < 5; k++) begin
        s = s ^ v;
        v = {v[6:0], v[7]};
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = tb_xt(rc);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp  = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_mul(a0, 8'h02) ^ tb_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_mul(a1, 8'h02) ^ tb_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_mul(a2, 8'h02) ^ tb_mul(a3, 8'h03);
          s[4*c+3] = tb_mul(a0, 8'h03) ^ a1 ^ a2 ^ tb_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*r + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Returns at the falling edge just after the accepting edge E0, with the
  // inputs scrambled so a late capture would show up.
  task automatic start_block(input logic [127:0] ct, input logic [255:0] key);
    @(negedge clk_i);
    ciphertext_i = ct;
    key_i        = key;
    en_i         = 1'b1;
    @(negedge clk_i);
    en_i         = 1'b0;
    ciphertext_i = ~ct;
    key_i        = ~key;
  endtask

  // Counts edges from E0 until done_o, bounded; also counts busy cycles.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy_o ? 1 : 0;
    while (!done_o && lat < 60) begin
      @(negedge clk_i);
      lat++;
      if (busy_o) busy_n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (plaintext_o !== 128'h0) begin bad++; $display("FAIL reset_pt: got %h want 0", plaintext_o); end
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  task automatic test_kat_c3();
    int lat, bn;
    start_block(C3_CT, C3_KEY);
    wait_done(lat, bn);
    total++; if (lat !== 28) begin bad++; $display("FAIL c3_latency: got %0d want 28", lat); end
    total++; if (bn !== 28) begin bad++; $display("FAIL c3_busy_cycles: got %0d want 28", bn); end
    total++; if (plaintext_o !== C3_PT) begin bad++; $display("FAIL c3_pt: got %h want %h", plaintext_o, C3_PT); end
  endtask

  task automatic test_idle_hold();
    int errs;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (plaintext_o !== C3_PT || done_o !== 1'b0 || busy_o !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL idle_hold: got %0d disturbed cycles want 0", errs); end
  endtask

  task automatic test_sp800();
    logic [127:0] cts [4];
    logic [127:0] pts [4];
    int lat, bn;
    cts = '{SP_CT1, SP_CT2, SP_CT3, SP_CT4};
    pts = '{SP_PT1, SP_PT2, SP_PT3, SP_PT4};
    for (int i = 0; i < 4; i++) begin
      start_block(cts[i], SP_KEY);
      wait_done(lat, bn);
      total++; if (plaintext_o !== pts[i]) begin bad++; $display("FAIL sp800_blk%0d: got %h want %h", i, plaintext_o, pts[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int lat, bn, spurious;
    start_block(C3_CT, C3_KEY);
    repeat (10) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done_o); end
    total++; if (plaintext_o !== 128'h0) begin bad++; $display("FAIL midrst_pt: got %h want 0", plaintext_o); end
    @(negedge clk_i);
    rst_n = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) spurious++;
    end
    total++; if (spurious !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", spurious); end
    start_block(C3_CT, C3_KEY);
    wait_done(lat, bn);
    total++; if (plaintext_o !== C3_PT) begin bad++; $display("FAIL midrst_fresh_pt: got %h want %h", plaintext_o, C3_PT); end
  endtask

  task automatic test_back_to_back();
    int           dn;
    int           dt [3];
    logic [127:0] dp [3];
    int           busy_at_done;
    dn = 0;
    busy_at_done = 0;
    @(negedge clk_i);
    ciphertext_i = C3_CT;
    key_i        = C3_KEY;
    en_i         = 1'b1;
    @(posedge clk_i);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_i);
      if (t == 5)  begin ciphertext_i = SP_CT1; key_i = SP_KEY; end
      if (t == 34) ciphertext_i = SP_CT2;
      if (t == 60) en_i = 1'b0;
      if (done_o) begin
        if (busy_o) busy_at_done++;
        if (dn < 3) begin dt[dn] = t; dp[dn] = plaintext_o; end
        dn++;
      end
    end
    en_i = 1'b0;
    total++; if (dn !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", dn); end
    if (dn >= 3) begin
      total++; if (dt[0] !== 28) begin bad++; $display("FAIL b2b_first_done: got %0d want 28", dt[0]); end
      total++; if (dt[1] - dt[0] !== 29) begin bad++; $display("FAIL b2b_gap1: got %0d want 29", dt[1] - dt[0]); end
      total++; if (dt[2] - dt[1] !== 29) begin bad++; $display("FAIL b2b_gap2: got %0d want 29", dt[2] - dt[1]); end
      total++; if (dp[0] !== C3_PT)  begin bad++; $display("FAIL b2b_pt0: got %h want %h", dp[0], C3_PT); end
      total++; if (dp[1] !== SP_PT1) begin bad++; $display("FAIL b2b_pt1: got %h want %h", dp[1], SP_PT1); end
      total++; if (dp[2] !== SP_PT2) begin bad++; $display("FAIL b2b_pt2: got %h want %h", dp[2], SP_PT2); end
    end
    total++; if (busy_at_done !== 0) begin bad++; $display("FAIL b2b_busy_at_done: got %0d want 0", busy_at_done); end
  endtask

  task automatic test_edge_keys();
    int lat, bn;
    logic [127:0] re;
    start_block(Z_CT, 256'h0);
    wait_done(lat, bn);
    total++; if (plaintext_o !== 128'h0) begin bad++; $display("FAIL zero_key_kat: got %h want 0", plaintext_o); end
    start_block(128'h0, 256'h0);
    wait_done(lat, bn);
    re = model_enc(plaintext_o, 256'h0);
    total++; if (re !== 128'h0) begin bad++; $display("FAIL zero_edge: enc(pt) got %h want 0", re); end
    start_block({128{1'b1}}, {256{1'b1}});
    wait_done(lat, bn);
    re = model_enc(plaintext_o, {256{1'b1}});
    total++; if (re !== {128{1'b1}}) begin bad++; $display("FAIL ones_edge: enc(pt) got %h want all ones", re); end
  endtask

  task automatic test_round_trip();
    int lat, bn, errs;
    logic [255:0] k;
    logic [127:0] p, c;
    k = 256'h7465737474657374746573747465737474657374746573747465737474657374;
    p = 128'h616c656e6b72757468616c656e6b7275;
    c = model_enc(p, k);
    start_block(c, k);
    wait_done(lat, bn);
    total++; if (plaintext_o !== p) begin bad++; $display("FAIL rt_directed: got %h want %h", plaintext_o, p); end
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = model_enc(p, k);
      start_block(c, k);
      wait_done(lat, bn);
      total++;
      if (plaintext_o !== p || lat !== 28) begin
        bad++;
        errs++;
        if (errs <= 5) $display("FAIL rt_random%0d: got %h lat %0d want %h lat 28", n, plaintext_o, lat, p);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat_c3();
    test_idle_hold();
    test_sp800();
    test_mid_reset();
    test_back_to_back();
    test_edge_keys();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes256_decrypt_core.md
# aes256_decrypt_core

Iterative AES-256 inverse cipher (FIPS-197 InvCipher), the decrypt-direction counterpart of the team's AES-256 encryption core. It accepts a 128-bit ciphertext block and a 256-bit key, then returns the 128-bit plaintext through the same `en_i` / `busy_o` / `done_o` handshake the encryption core uses. Internally it expands the key once per block into a round-key register file, then runs one inverse round per clock. It sits beside the encryption core in the crypto subsystem and serves ECB/CBC-decrypt paths and round-trip self-test.

## Interface
- No parameters. Key size is fixed at 256 bits (Nk=8, Nr=14).
- `clk_i` in 1: single clock, rising edge, free-running.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_i` in 1: start request; sampled only in IDLE.
- `ciphertext_i` in 128: input block, FIPS byte order (bits [127:120] = byte 0).
- `key_i` in 256: cipher key, FIPS byte order.
- `plaintext_o` out 128: result, registered; holds until the next completion.
- `busy_o` out 1: high whenever state != IDLE.
- `done_o` out 1: one-cycle pulse when `plaintext_o` updates.

## Operation
- FSM states: IDLE, KEYEXP, INIT, ROUND, FINAL.
- IDLE, with `en_i`=1 at an edge:
  - Capture `ciphertext_i` into the state register and `key_i` into rk[0] (bits 255:128) and rk[1] (bits 127:0).
  - Clear the round counter. Go to KEYEXP.
  - Inputs are not sampled again until the next IDLE acceptance.
- KEYEXP, 13 cycles:
  - Each cycle produces rk[n], n = 2..14, as 4 words from the previous 8 words.
  - First word of an even n: RotWord, SubWord, and Rcon[n/2] (01,02,04,08,10,20,40).
  - First word of an odd n: SubWord only.
  - Remaining words: XOR chain.
  - After rk[14] is written, go to INIT.
- INIT, 1 cycle: state ^= rk[14]; round counter r = 13. Go to ROUND.
- ROUND, 13 cycles, r = 13 down to 1:
  - state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
  - After r = 1, go to FINAL.
- FINAL, 1 cycle:
  - `plaintext_o` = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]).
  - Assert `done_o` for the following cycle. Go to IDLE.
- S-box and inverse S-box are computed as GF(2^8) inverse (poly 0x11B, 0 maps to 0) plus the forward or inverse affine transform. A 256-entry table is equally acceptable.
  - Datapath: 16 inverse S-boxes for the state, 4 forward S-boxes for key expansion.
- InvMixColumns uses fixed coefficients {0e,0b,0d,09} via xtime chains. No multipliers.
- `en_i` is ignored while `busy_o`=1; there is no queueing or abort.
- Reset (async, any state):
  - FSM goes to IDLE; state register, round keys and round counter clear to 0.
  - `plaintext_o`=0, `busy_o`=0, `done_o`=0.
  - An in-flight block is discarded with no `done_o`.

## Timing
- Edge E0 samples `en_i`=1 in IDLE; `busy_o` is high from E0 onward.
- E1–E13: KEYEXP. E14: INIT. E15–E27: ROUND. E28: FINAL.
- After E28: `done_o`=1 for exactly one cycle (E28 to E29), `busy_o`=0, `plaintext_o` valid.
- Latency from the accepting edge to the `done_o` edge is 28 cycles.
- `en_i`=1 during the `done_o` cycle is accepted at E29 (FSM already in IDLE). Back-to-back throughput is one block per 29 cycles.
- `plaintext_o` changes only at the FINAL edge or at reset. It is stable while `busy_o` is high for the next block.
- `ciphertext_i` and `key_i` may change any time after E0 without effect.

## Test plan
- FIPS-197 C.3 known answer:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, ct 8ea2b7ca516745bfeafc49904b496089, en_i pulse.
  - Required: `done_o` exactly 28 cycles after acceptance; `plaintext_o`=00112233445566778899aabbccddeeff; `busy_o` high for exactly 28 cycles.
- Round trip with the encryption core:
  - Stimulus: encrypt pt 616c656e6b72757468616c656e6b7275 under key 7465737474657374746573747465737474657374746573747465737474657374, then feed the core's ciphertext here with the same key.
  - Required: `plaintext_o`=616c656e6b72757468616c656e6b7275.
  - Repeat for 1000 random key/pt pairs; every pair must match.
- Busy and back-to-back:
  - Stimulus: hold `en_i`=1 continuously and change `ciphertext_i`/`key_i` mid-block.
  - Required: the first result is unaffected; `done_o` pulses every 29 cycles; each result corresponds to the inputs captured at its accepting edge.
- Mid-operation reset:
  - Stimulus: assert `rst_n`=0 asynchronously (between edges) at cycle 10 of a block.
  - Required: `busy_o`, `done_o` and `plaintext_o` are 0 immediately; no `done_o` for the aborted block; a fresh C.3 block after release still yields 00112233445566778899aabbccddeeff.
- Idle hold:
  - Stimulus: after completion, leave `en_i`=0 for 100 cycles.
  - Required: `plaintext_o` holds its value, `done_o` stays 0, `busy_o` stays 0.
- Edge keys:
  - Stimulus: all-zero key with all-zero ct, and all-ones key with all-ones ct.
  - Required: `plaintext_o` equals the software reference model's InvCipher output, bit for bit.
